// File: rtl/div_by_sub_if.sv
// Start/rdy handshake bundle for the repeated-subtraction divider.
// The master side issues operands; the slave side is the divider.
interface div_by_sub_if #(
  parameter int data_width = 4
);
  logic                      start;
  logic [2*data_width-1:0]   N;
  logic [data_width-1:0]     D;
  logic [2*data_width-1:0]   Q;
  logic [data_width-1:0]     R;
  logic                      rdy;
  logic                      dz;

  modport master (output start, N, D, input Q, R, rdy, dz);
  modport slave  (input start, N, D, output Q, R, rdy, dz);
endinterface

// File: rtl/div_by_sub.sv
// Sequential unsigned divider: subtracts the divisor from the dividend once
// per clock until the running remainder drops below the divisor.
//
// state | meaning
// IDLE  | waiting for start; Q/R/dz hold the last result, rdy=1
// RUN   | one subtraction per edge; completes when RN < RD
module div_by_sub #(
  parameter int data_width = 4
) (
  input  logic          clk,
  input  logic          rst,
  div_by_sub_if.slave   bus
);
  localparam int QW = 2 * data_width;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [QW-1:0]           rn, rn_nxt;
  logic [data_width-1:0]   rd, rd_nxt;
  logic [QW-1:0]           rq, rq_nxt;
  logic [QW-1:0]           q_r, q_nxt;
  logic [data_width-1:0]   r_r, r_nxt;
  logic                    rdy_r, rdy_nxt;
  logic                    dz_r, dz_nxt;
  logic [QW-1:0]           rd_ext;
  logic                    rn_ge_rd;

  // Divisor widened to dividend width for the compare and subtract.
  assign rd_ext   = {{data_width{1'b0}}, rd};
  assign rn_ge_rd = (rn >= rd_ext);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath next values; everything holds unless changed.
  always_comb begin
    state_nxt = state;
    rn_nxt    = rn;
    rd_nxt    = rd;
    rq_nxt    = rq;
    q_nxt     = q_r;
    r_nxt     = r_r;
    rdy_nxt   = rdy_r;
    dz_nxt    = dz_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.D != '0) begin
            rn_nxt    = bus.N;
            rd_nxt    = bus.D;
            rq_nxt    = '0;
            dz_nxt    = 1'b0;
            rdy_nxt   = 1'b0;
            state_nxt = RUN;
          end else begin
            // Zero divisor resolves immediately without leaving IDLE.
            dz_nxt = 1'b1;
            q_nxt  = '1;
            r_nxt  = '0;
          end
        end
      end
      RUN: begin
        if (rn_ge_rd) begin
          rn_nxt = rn - rd_ext;
          rq_nxt = rq + {{(QW-1){1'b0}}, 1'b1};
        end else begin
          // RN < RD here, so the low bits hold the whole remainder.
          q_nxt     = rq;
          r_nxt     = rn[data_width-1:0];
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rn    <= '0;
      rd    <= '0;
      rq    <= '0;
      q_r   <= '0;
      r_r   <= '0;
      rdy_r <= 1'b1;
      dz_r  <= 1'b0;
    end else begin
      rn    <= rn_nxt;
      rd    <= rd_nxt;
      rq    <= rq_nxt;
      q_r   <= q_nxt;
      r_r   <= r_nxt;
      rdy_r <= rdy_nxt;
      dz_r  <= dz_nxt;
    end
  end

  assign bus.Q   = q_r;
  assign bus.R   = r_r;
  assign bus.rdy = rdy_r;
  assign bus.dz  = dz_r;
endmodule

// File: tb/tb_div_by_sub.sv
// Directed and random bench for div_by_sub at data_width=4.
module tb_div_by_sub;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  div_by_sub_if #(.data_width(DW)) bus ();

  div_by_sub #(.data_width(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present operands with start at a falling edge, let the next rising edge
  // accept them, then drop start 1 time unit after that edge.
  task automatic accept(input logic [7:0] n, input logic [3:0] d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.N     = n;
    bus.D     = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until rdy is seen high.
  task automatic wait_rdy(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.rdy !== 1'b1 && lat < 400);
    total++;
    if (bus.rdy !== 1'b1) begin
      bad++;
      $display("FAIL wait_rdy: rdy=%b after %0d edges, required 1", bus.rdy, lat);
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.N = '0;
    bus.D = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", bus.rdy); end
    total++; if (bus.Q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", bus.Q); end
    total++; if (bus.R !== 4'h0) begin bad++; $display("FAIL reset_r: got %h want 0", bus.R); end
    total++; if (bus.dz !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", bus.dz); end
    // Give Q a nonzero value so the mid-run reset has something to clear.
    accept(8'h14, 4'd4);
    wait_rdy(lat);
    accept(8'hFF, 4'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy: got %b want 1", bus.rdy); end
    total++; if (bus.Q !== 8'h00) begin bad++; $display("FAIL abort_q: got %h want 00", bus.Q); end
    total++; if (bus.R !== 4'h0) begin bad++; $display("FAIL abort_r: got %h want 0", bus.R); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL abort_idle: rdy got %b want 1", bus.rdy); end
    total++; if (bus.Q !== 8'h00) begin bad++; $display("FAIL abort_hold_q: got %h want 00", bus.Q); end
  endtask

  task automatic test_basic();
    int lat;
    accept(8'h14, 4'd4);
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL basic_busy: rdy got %b want 0", bus.rdy); end
    wait_rdy(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL basic_lat: got %0d want 6", lat); end
    total++; if (bus.Q !== 8'h05) begin bad++; $display("FAIL basic_q: got %h want 05", bus.Q); end
    total++; if (bus.R !== 4'h0) begin bad++; $display("FAIL basic_r: got %h want 0", bus.R); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.Q !== 8'h05 || bus.R !== 4'h0 || bus.rdy !== 1'b1) begin
      bad++; $display("FAIL basic_hold: Q=%h R=%h rdy=%b want 05 0 1", bus.Q, bus.R, bus.rdy);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] tn [3] = '{8'h07, 8'hE1, 8'hFF};
    logic [3:0] td [3] = '{4'd9, 4'hF, 4'd1};
    logic [7:0] tq [3] = '{8'h00, 8'h0F, 8'hFF};
    logic [3:0] tr [3] = '{4'h7, 4'h0, 4'h0};
    int         tl [3] = '{1, 16, 256};
    int lat;
    for (int i = 0; i < 3; i++) begin
      accept(tn[i], td[i]);
      wait_rdy(lat);
      total++; if (lat != tl[i]) begin bad++; $display("FAIL bound%0d_lat: got %0d want %0d", i, lat, tl[i]); end
      total++; if (bus.Q !== tq[i]) begin bad++; $display("FAIL bound%0d_q: got %h want %h", i, bus.Q, tq[i]); end
      total++; if (bus.R !== tr[i]) begin bad++; $display("FAIL bound%0d_r: got %h want %h", i, bus.R, tr[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    accept(8'h33, 4'd0);
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL dz_rdy: got %b want 1", bus.rdy); end
    total++; if (bus.dz !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", bus.dz); end
    total++; if (bus.Q !== 8'hFF) begin bad++; $display("FAIL dz_q: got %h want FF", bus.Q); end
    total++; if (bus.R !== 4'h0) begin bad++; $display("FAIL dz_r: got %h want 0", bus.R); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.dz !== 1'b1) begin bad++; $display("FAIL dz_sticky: got %b want 1", bus.dz); end
    accept(8'h0B, 4'd3);
    total++; if (bus.dz !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", bus.dz); end
    wait_rdy(lat);
    total++; if (bus.Q !== 8'h03) begin bad++; $display("FAIL dz_next_q: got %h want 03", bus.Q); end
    total++; if (bus.R !== 4'h2) begin bad++; $display("FAIL dz_next_r: got %h want 2", bus.R); end
  endtask

  task automatic test_handshake();
    int lat;
    accept(8'h64, 4'd5);
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1;
    bus.N = 8'h01;
    bus.D = 4'd1;
    @(posedge clk); #1; lat++;
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL hs_ignore: rdy got %b want 0", bus.rdy); end
    bus.start = 1'b0;
    @(posedge clk); #1; lat++;
    // Hold start high from here on with the next operands.
    bus.start = 1'b1;
    bus.N = 8'h0A;
    bus.D = 4'd2;
    while (bus.rdy !== 1'b1 && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    total++; if (lat != 21) begin bad++; $display("FAIL hs_lat: got %0d want 21", lat); end
    total++; if (bus.Q !== 8'h14) begin bad++; $display("FAIL hs_q: got %h want 14", bus.Q); end
    total++; if (bus.R !== 4'h0) begin bad++; $display("FAIL hs_r: got %h want 0", bus.R); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL hs_accept: rdy got %b want 0", bus.rdy); end
    total++; if (bus.Q !== 8'h14) begin bad++; $display("FAIL hs_qhold: got %h want 14", bus.Q); end
    wait_rdy(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL hs_b2b_lat: got %0d want 6", lat); end
    total++; if (bus.Q !== 8'h05) begin bad++; $display("FAIL hs_b2b_q: got %h want 05", bus.Q); end
    total++; if (bus.R !== 4'h0) begin bad++; $display("FAIL hs_b2b_r: got %h want 0", bus.R); end
  endtask

  task automatic test_random();
    logic [7:0] n;
    logic [3:0] d;
    int lat;
    int qv, rv;
    for (int i = 0; i < 200; i++) begin
      n = 8'($urandom_range(0, 255));
      d = 4'($urandom_range(1, 15));
      accept(n, d);
      wait_rdy(lat);
      qv = int'(bus.Q);
      rv = int'(bus.R);
      total++; if (qv * int'(d) + rv != int'(n)) begin
        bad++; $display("FAIL rnd_inv: N=%h D=%h got Q=%h R=%h", n, d, bus.Q, bus.R);
      end
      total++; if (rv >= int'(d)) begin bad++; $display("FAIL rnd_rem: R=%h want < D=%h", bus.R, d); end
      total++; if (qv != int'(n) / int'(d)) begin
        bad++; $display("FAIL rnd_q: N=%h D=%h got %h want %h", n, d, bus.Q, int'(n) / int'(d));
      end
      total++; if (lat != qv + 1) begin bad++; $display("FAIL rnd_lat: got %0d want %0d", lat, qv + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_handshake();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_by_sub.md
Name: div_by_sub

Overview:
- Sequential unsigned divider that computes quotient and remainder by repeated subtraction of the divisor from the dividend.
- It is the inverse companion of the team's multiply-by-repeated-addition unit: it takes a 2*data_width product-width dividend and a data_width divisor.
- It uses the same start/rdy controller handshake, so both blocks share one control style in the datapath.

Parameters:
- data_width, 4: operand width in bits. Divisor and remainder are data_width bits; dividend and quotient are 2*data_width bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle request; sampled only while rdy=1
- N  input  2*data_width  unsigned dividend; sampled on the accepting edge
- D  input  data_width  unsigned divisor; sampled on the accepting edge
- Q  output  2*data_width  quotient, registered
- R  output  data_width  remainder, registered
- rdy  output  1  1 = idle and results valid/held; 0 = division in progress
- dz  output  1  divide-by-zero flag, registered

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, Q=0, R=0, rdy=1, dz=0; internal RN/RD/RQ registers cleared. Reset has priority over everything. Reset mid-operation aborts the division with no result update beyond the reset values.
- States: IDLE, RUN.
- IDLE, start=1, D!=0:
  - Load RN<=N, RD<=D, RQ<=0, dz<=0, rdy<=0; go to RUN.
  - Q and R keep their previous values until completion.
- IDLE, start=1, D==0:
  - Stay in IDLE; rdy stays 1.
  - dz<=1, Q<=all ones, R<=0.
- IDLE, start=0: hold all outputs.
- RUN, each edge:
  - If RN>=RD: RN<=RN-RD, RQ<=RQ+1; stay in RUN.
  - Else: Q<=RQ, R<=RN[data_width-1:0], rdy<=1; go to IDLE.
  - RN<RD guarantees RN fits in data_width bits.
- Latency for quotient q: rdy falls on the accepting edge and rises q+1 edges later. Range is 1 (N<D) to 2^(2*data_width) (N=all ones, D=1).
- start while rdy=0 is ignored; N and D may change freely during RUN.
- start held high continuously: a new division is accepted on the first edge after rdy returns to 1. The result is visible for exactly one cycle with rdy=1 before the next start is accepted.
- Arithmetic:
  - All unsigned. RQ is 2*data_width bits and cannot overflow, since q <= N.
  - RN>=RD compares RD zero-extended to 2*data_width.
- dz stays set until the next accepted start with D!=0, or until reset.
- Invariant: N == Q*D + R and R < D for every completed non-zero-divisor operation.

Test Plan (data_width=4):
1. Reset: hold rst=1 for 2 edges, then release -> rdy=1, Q=0x00, R=0x0, dz=0. Apply rst=1 3 cycles into a division of N=0xFF, D=1 -> next edge rdy=1, Q=0, state IDLE.
2. Basic: N=0x14 (20), D=4, pulse start 1 cycle -> rdy=0 after the accepting edge, rdy=1 after 6 edges, Q=0x05, R=0x0. Q/R hold afterwards with start=0.
3. Boundaries:
   - N=0x07, D=9 -> Q=0x00, R=0x7, latency 1.
   - N=0xE1, D=0xF -> Q=0x0F, R=0x0, latency 16.
   - N=0xFF, D=1 -> Q=0xFF, R=0x0, latency 256.
4. Divide by zero: N=0x33, D=0, start -> rdy stays 1, dz=1, Q=0xFF, R=0x0. Then N=0x0B, D=3, start -> dz=0, Q=0x03, R=0x2.
5. Handshake: during RUN for N=0x64, D=5, pulse start with N=0x01, D=1 -> ignored; result Q=0x14, R=0x0. Then hold start=1 with N=0x0A, D=2 -> next division is accepted the edge after rdy rises; Q=0x05.
6. Random: 200 random (N, D!=0) pairs -> scoreboard checks N==Q*D+R, R<D, and latency == Q+1 edges.
